// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered or first-word-fall-through read, synchronous flush,
// programmable almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module sync_fifo_flags #(
    parameter int DWIDTH    = 16,
    parameter int AWIDTH    = 8,
    parameter bit FWFT      = 1'b0,
    parameter int AFULL_TH  = (1 << AWIDTH) - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              write_en,
    input  logic [DWIDTH-1:0] write_data,
    input  logic              read_en,
    output logic [DWIDTH-1:0] read_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_L   = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] AFULL_L   = (AWIDTH + 1)'(AFULL_TH);
    localparam logic [AWIDTH:0] AEMPTY_L  = (AWIDTH + 1)'(AEMPTY_TH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wptr;
    logic [AWIDTH-1:0] rptr;
    logic              flush;
    logic              wr_acc;
    logic              rd_acc;

    // rst and clear are equivalent: both flush every piece of control state.
    assign flush  = rst | clear;

    // Full and empty are told apart by level alone, since wptr == rptr in both cases.
    assign full         = (level == DEPTH_L);
    assign empty        = (level == '0);
    assign almost_full  = (level >= AFULL_L);
    assign almost_empty = (level <= AEMPTY_L);

    assign wr_acc = write_en & ~full;
    assign rd_acc = read_en & ~empty;

    always_ff @(posedge clk) begin
        if (!flush && wr_acc) begin
            mem[wptr] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (write_en && full) begin
                overflow <= 1'b1;
            end
            if (read_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is presented combinationally; read_en only advances rptr.
            assign read_data = empty ? '0 : mem[rptr];
        end else begin : g_registered
            always_ff @(posedge clk) begin
                if (flush) begin
                    read_data <= '0;
                end else if (rd_acc) begin
                    read_data <= mem[rptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: one registered-read instance and one FWFT instance,
// both 16 deep, driven through fixed stimulus sequences with hand-computed expectations.
module tb_sync_fifo_flags;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read instance
    logic        rst = 1'b1, clear = 1'b0, we = 1'b0, re = 1'b0;
    logic [15:0] wd = '0;
    logic [15:0] rd;
    logic        full, empty, afull, aempty, ovf, unf;
    logic [4:0]  lvl;

    // FWFT instance
    logic        f_rst = 1'b1, f_clear = 1'b0, f_we = 1'b0, f_re = 1'b0;
    logic [15:0] f_wd = '0;
    logic [15:0] f_rd;
    logic        f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
    logic [4:0]  f_lvl;

    int n_chk  = 0;
    int n_fail = 0;

    sync_fifo_flags #(.DWIDTH(16), .AWIDTH(4), .FWFT(1'b0)) u_reg (
        .clk(clk), .rst(rst), .clear(clear), .write_en(we), .write_data(wd), .read_en(re),
        .read_data(rd), .full(full), .empty(empty), .almost_full(afull), .almost_empty(aempty),
        .level(lvl), .overflow(ovf), .underflow(unf)
    );

    sync_fifo_flags #(.DWIDTH(16), .AWIDTH(4), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(f_rst), .clear(f_clear), .write_en(f_we), .write_data(f_wd), .read_en(f_re),
        .read_data(f_rd), .full(f_full), .empty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty),
        .level(f_lvl), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] wv;
    logic [15:0] rv;

    initial begin
        // Reset state
        tick(); tick();
        rst = 1'b0; f_rst = 1'b0;
        check("rst_level", lvl, 0);
        check("rst_empty", empty, 1);
        check("rst_aempty", aempty, 1);
        check("rst_full", full, 0);
        check("rst_afull", afull, 0);
        check("rst_ovf", ovf, 0);
        check("rst_unf", unf, 0);
        check("rst_rd", rd, 0);

        // Fill 0x0001..0x0010
        for (int i = 1; i <= 16; i++) begin
            we = 1'b1; wd = 16'(i);
            tick();
            check("fill_level", lvl, i);
            check("fill_afull", afull, (i >= 12));
            check("fill_aempty", aempty, (i <= 4));
            check("fill_full", full, (i == 16));
        end
        we = 1'b0;

        // Overflow while full
        we = 1'b1; wd = 16'hDEAD;
        tick();
        we = 1'b0;
        check("ovf_flag", ovf, 1);
        check("ovf_level", lvl, 16);
        check("ovf_full", full, 1);

        // Drain, 1-cycle read latency
        for (int i = 1; i <= 16; i++) begin
            re = 1'b1;
            tick();
            check("drain_rd", rd, i);
            check("drain_level", lvl, 16 - i);
        end
        re = 1'b0;
        check("drain_empty", empty, 1);

        // Underflow while empty; read_data holds
        re = 1'b1;
        tick();
        re = 1'b0;
        check("unf_flag", unf, 1);
        check("unf_rd_hold", rd, 16'h0010);
        check("unf_level", lvl, 0);
        check("unf_ovf_sticky", ovf, 1);

        // Clear pulse
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_ovf", ovf, 0);
        check("clr_unf", unf, 0);
        check("clr_rd", rd, 0);

        // Simultaneous read/write at level 5 across pointer wrap
        for (int i = 0; i < 5; i++) begin
            we = 1'b1; wd = 16'h0100 + 16'(i);
            tick();
        end
        we = 1'b0;
        check("sim_pre_level", lvl, 5);
        wv = 16'h0105;
        rv = 16'h0100;
        for (int i = 0; i < 40; i++) begin
            we = 1'b1; re = 1'b1; wd = wv;
            tick();
            check("sim_rd", rd, rv);
            check("sim_level", lvl, 5);
            wv++; rv++;
        end
        we = 1'b0; re = 1'b0;
        check("sim_ovf", ovf, 0);
        check("sim_unf", unf, 0);
        check("sim_full", full, 0);
        check("sim_empty", empty, 0);

        // Top up to full, then read+write while full
        for (int i = 0; i < 11; i++) begin
            we = 1'b1; wd = wv;
            tick();
            wv++;
        end
        we = 1'b0;
        check("top_full", full, 1);
        we = 1'b1; re = 1'b1; wd = 16'hBEEF;
        tick();
        we = 1'b0; re = 1'b0;
        check("fullrw_level", lvl, 15);
        check("fullrw_ovf", ovf, 1);
        check("fullrw_rd", rd, rv);
        rv++;
        for (int i = 0; i < 15; i++) begin
            re = 1'b1;
            tick();
            check("fullrw_drain", rd, rv);
            rv++;
        end
        re = 1'b0;
        check("fullrw_empty", empty, 1);

        // Mid-operation reset with a concurrent write
        for (int i = 0; i < 9; i++) begin
            we = 1'b1; wd = 16'h0700 + 16'(i);
            tick();
        end
        check("mid_pre_level", lvl, 9);
        rst = 1'b1; we = 1'b1; wd = 16'h5555;
        tick();
        rst = 1'b0; we = 1'b0;
        check("mid_level", lvl, 0);
        check("mid_empty", empty, 1);
        check("mid_ovf", ovf, 0);
        check("mid_rd", rd, 0);
        check("mid_aempty", aempty, 1);
        we = 1'b1; wd = 16'h1234;
        tick();
        we = 1'b0;
        check("mid_wr_level", lvl, 1);
        re = 1'b1;
        tick();
        re = 1'b0;
        check("mid_rd_1234", rd, 16'h1234);

        // FWFT instance
        check("f_rst_empty", f_empty, 1);
        check("f_rst_rd", f_rd, 0);
        f_we = 1'b1; f_wd = 16'hA5A5;
        tick();
        f_we = 1'b0;
        check("f_empty_after_wr", f_empty, 0);
        check("f_rd_fall", f_rd, 16'hA5A5);
        f_re = 1'b1;
        tick();
        f_re = 1'b0;
        check("f_pop_empty", f_empty, 1);
        check("f_pop_rd", f_rd, 0);
        f_we = 1'b1; f_wd = 16'h1111;
        tick();
        f_wd = 16'h2222;
        tick();
        f_we = 1'b0;
        check("f_two_rd", f_rd, 16'h1111);
        check("f_two_level", f_lvl, 2);
        f_re = 1'b1;
        tick();
        check("f_next_rd", f_rd, 16'h2222);
        tick();
        check("f_last_empty", f_empty, 1);
        check("f_last_rd", f_rd, 0);
        tick();
        f_re = 1'b0;
        check("f_unf", f_unf, 1);
        check("f_unf_rd", f_rd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
